// File: rtl/draw_sequencer_if.sv
// Client-side drawing bus plus the registered pixel port towards the VGA adapter.
// The sequencer takes the master modport; clients and the adapter take the slave modport.
interface draw_sequencer_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int C_W         = 3
);
  logic [NUM_CLIENTS-1:0]     client_done;
  logic [NUM_CLIENTS-1:0]     client_we;
  logic [NUM_CLIENTS*X_W-1:0] client_x;
  logic [NUM_CLIENTS*Y_W-1:0] client_y;
  logic [NUM_CLIENTS*C_W-1:0] client_c;
  logic [NUM_CLIENTS-1:0]     client_go;
  logic                       plot;
  logic [X_W-1:0]             x_out;
  logic [Y_W-1:0]             y_out;
  logic [C_W-1:0]             color_out;

  modport master (
    input  client_done, client_we, client_x, client_y, client_c,
    output client_go, plot, x_out, y_out, color_out
  );

  modport slave (
    output client_done, client_we, client_x, client_y, client_c,
    input  client_go, plot, x_out, y_out, color_out
  );
endinterface

// File: rtl/draw_sequencer.sv
// Time-multiplexes drawing clients onto one pixel-write port: client 0 runs once after reset,
// then rounds grant each masked-in client in ascending order with a go/done handshake.
module draw_sequencer #(
  parameter int NUM_CLIENTS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int C_W         = 3,
  parameter int FRAME_PACE  = 1,
  parameter int TIMEOUT     = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   frame_tick,
  input  logic [NUM_CLIENTS-1:0] client_mask,
  draw_sequencer_if.master       bus,
  output logic [3:0]             active_idx,
  output logic                   round_done,
  output logic                   init_done,
  output logic                   timeout_err
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_INIT, S_WAIT, S_SELECT, S_RUN, S_ROUND_END
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_CLIENTS-1:0] go_q, go_d;
  logic [NUM_CLIENTS-1:0] mask_q, mask_d;
  logic [3:0]             active_q, active_d;
  logic [4:0]             idx_q, idx_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   init_done_q, init_done_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   plot_q, plot_d;
  logic [X_W-1:0]         x_q, x_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic [C_W-1:0]         c_q, c_d;

  logic                   done_sel, we_sel, granted, wd_fire, release_grant, found;
  logic [3:0]             found_idx;
  logic [X_W-1:0]         x_sel;
  logic [Y_W-1:0]         y_sel;
  logic [C_W-1:0]         c_sel;

  always_comb begin
    done_sel  = 1'b0;
    we_sel    = 1'b0;
    x_sel     = '0;
    y_sel     = '0;
    c_sel     = '0;
    found     = 1'b0;
    found_idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (active_q == 4'(i)) begin
        done_sel = bus.client_done[i];
        we_sel   = bus.client_we[i];
        x_sel    = bus.client_x[i*X_W +: X_W];
        y_sel    = bus.client_y[i*Y_W +: Y_W];
        c_sel    = bus.client_c[i*C_W +: C_W];
      end
    end
    // Descending scan so the lowest eligible index at or above idx_q wins.
    for (int i = NUM_CLIENTS - 1; i >= 1; i--) begin
      if (mask_q[i] && (5'(i) >= idx_q)) begin
        found     = 1'b1;
        found_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    idx_d         = idx_q;
    mask_d        = mask_q;
    init_done_d   = init_done_q;
    timeout_err_d = timeout_err_q;
    wd_d          = '0;
    go_d          = '0;

    granted       = |go_q;
    wd_fire       = (TIMEOUT != 0) && granted && (wd_q == WD_LAST);
    release_grant = granted && (done_sel || wd_fire);

    case (state_q)
      S_INIT: begin
        if (release_grant) begin
          init_done_d = 1'b1;
          if (!done_sel) timeout_err_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (enable && ((FRAME_PACE == 0) || frame_tick)) begin
          mask_d    = client_mask;
          mask_d[0] = 1'b0;
          idx_d     = 5'd1;
          state_d   = S_SELECT;
        end
      end
      S_SELECT: begin
        if (found) begin
          active_d = found_idx;
          state_d  = S_RUN;
        end else begin
          state_d = S_ROUND_END;
        end
      end
      S_RUN: begin
        if (release_grant) begin
          if (!done_sel) timeout_err_d = 1'b1;
          idx_d   = 5'(active_q) + 5'd1;
          state_d = S_SELECT;
        end
      end
      S_ROUND_END: state_d = S_WAIT;
      default:     state_d = S_INIT;
    endcase

    if (granted && !release_grant) wd_d = wd_q + WD_W'(1);

    // Go is registered from the next state, so it drops the cycle after done is seen.
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      go_d[i] = ((state_d == S_RUN) && (active_d == 4'(i))) ||
                ((state_d == S_INIT) && (i == 0));
    end

    plot_d = we_sel && ((state_q == S_INIT) || (state_q == S_RUN));
    x_d    = plot_d ? x_sel : x_q;
    y_d    = plot_d ? y_sel : y_q;
    c_d    = plot_d ? c_sel : c_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_INIT;
      go_q          <= '0;
      mask_q        <= '0;
      active_q      <= '0;
      idx_q         <= '0;
      wd_q          <= '0;
      init_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      plot_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      c_q           <= '0;
    end else begin
      state_q       <= state_d;
      go_q          <= go_d;
      mask_q        <= mask_d;
      active_q      <= active_d;
      idx_q         <= idx_d;
      wd_q          <= wd_d;
      init_done_q   <= init_done_d;
      timeout_err_q <= timeout_err_d;
      plot_q        <= plot_d;
      x_q           <= x_d;
      y_q           <= y_d;
      c_q           <= c_d;
    end
  end

  assign bus.client_go = go_q;
  assign bus.plot      = plot_q;
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.color_out = c_q;
  assign active_idx    = active_q;
  assign round_done    = (state_q == S_ROUND_END);
  assign init_done     = init_done_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench: a paced instance with a short watchdog, plus an unpaced instance with an empty mask.
module tb_draw_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] client_mask = 4'b0000;
  logic [3:0] active_idx;
  logic       round_done, init_done, timeout_err;

  logic [3:0] mask2 = 4'b0000;
  logic [3:0] active_idx2;
  logic       round_done2, init_done2, timeout_err2;

  int checks = 0;
  int errors = 0;

  draw_sequencer_if #(.NUM_CLIENTS(4), .X_W(8), .Y_W(7), .C_W(3)) bus ();
  draw_sequencer_if #(.NUM_CLIENTS(4), .X_W(8), .Y_W(7), .C_W(3)) bus2 ();

  draw_sequencer #(
    .NUM_CLIENTS(4), .X_W(8), .Y_W(7), .C_W(3), .FRAME_PACE(1), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .client_mask(client_mask), .bus(bus), .active_idx(active_idx),
    .round_done(round_done), .init_done(init_done), .timeout_err(timeout_err)
  );

  draw_sequencer #(
    .NUM_CLIENTS(4), .X_W(8), .Y_W(7), .C_W(3), .FRAME_PACE(0), .TIMEOUT(0)
  ) dut2 (
    .clk(clk), .reset(reset), .enable(1'b1), .frame_tick(1'b0),
    .client_mask(mask2), .bus(bus2), .active_idx(active_idx2),
    .round_done(round_done2), .init_done(init_done2), .timeout_err(timeout_err2)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    bit found;
    bus.client_done = '0; bus.client_we = '0;
    bus.client_x = '0; bus.client_y = '0; bus.client_c = '0;
    bus2.client_done = 4'b0001; bus2.client_we = '0;
    bus2.client_x = '0; bus2.client_y = '0; bus2.client_c = '0;

    applyStimulus(2);
    checkOutput("reset go", bus.client_go, 4'b0000);
    checkOutput("reset plot", bus.plot, 1'b0);
    checkOutput("reset x", bus.x_out, 8'h00);
    checkOutput("reset idx", active_idx, 4'd0);
    checkOutput("reset round_done", round_done, 1'b0);
    checkOutput("reset init_done", init_done, 1'b0);
    checkOutput("reset timeout_err", timeout_err, 1'b0);

    reset = 1'b0;
    applyStimulus(1);
    checkOutput("init go", bus.client_go, 4'b0001);
    applyStimulus(3);
    checkOutput("init held", bus.client_go, 4'b0001);
    checkOutput("init_done low", init_done, 1'b0);

    bus.client_done[0] = 1'b1; bus.client_we[0] = 1'b1;
    bus.client_x[7:0] = 8'h11; bus.client_y[6:0] = 7'h22; bus.client_c[2:0] = 3'b011;
    applyStimulus(1);
    checkOutput("init released go", bus.client_go, 4'b0000);
    checkOutput("init_done set", init_done, 1'b1);
    checkOutput("init plot", bus.plot, 1'b1);
    checkOutput("init x", bus.x_out, 8'h11);
    checkOutput("init y", bus.y_out, 7'h22);
    bus.client_done[0] = 1'b0; bus.client_we[0] = 1'b0;
    applyStimulus(1);
    checkOutput("init plot off", bus.plot, 1'b0);

    enable = 1'b1; client_mask = 4'b1110;
    applyStimulus(3);
    checkOutput("paced wait go", bus.client_go, 4'b0000);
    frame_tick = 1'b1;
    applyStimulus(1);
    frame_tick = 1'b0;
    checkOutput("select gap go", bus.client_go, 4'b0000);
    applyStimulus(1);
    checkOutput("round1 go c1", bus.client_go, 4'b0010);
    checkOutput("round1 idx c1", active_idx, 4'd1);

    bus.client_we = 4'b0110;
    bus.client_x[15:8] = 8'h25; bus.client_y[13:7] = 7'h10; bus.client_c[5:3] = 3'b101;
    bus.client_x[23:16] = 8'h3F; bus.client_y[20:14] = 7'h7F; bus.client_c[8:6] = 3'b111;
    bus.client_done[2] = 1'b1;
    applyStimulus(1);
    checkOutput("mux plot", bus.plot, 1'b1);
    checkOutput("mux x", bus.x_out, 8'h25);
    checkOutput("mux y", bus.y_out, 7'h10);
    checkOutput("mux c", bus.color_out, 3'b101);
    checkOutput("foreign done ignored", bus.client_go, 4'b0010);
    bus.client_we = 4'b0000; bus.client_done[2] = 1'b0;
    applyStimulus(1);
    checkOutput("mux plot off", bus.plot, 1'b0);
    checkOutput("mux x hold", bus.x_out, 8'h25);

    bus.client_done[1] = 1'b1;
    applyStimulus(1);
    bus.client_done[1] = 1'b0;
    checkOutput("gap after c1", bus.client_go, 4'b0000);
    applyStimulus(1);
    checkOutput("round1 go c2", bus.client_go, 4'b0100);
    checkOutput("round1 idx c2", active_idx, 4'd2);
    applyStimulus(15);
    checkOutput("wdog still held", bus.client_go, 4'b0100);
    checkOutput("wdog not yet", timeout_err, 1'b0);
    applyStimulus(1);
    checkOutput("wdog drops go", bus.client_go, 4'b0000);
    checkOutput("wdog err set", timeout_err, 1'b1);
    applyStimulus(1);
    checkOutput("round1 go c3", bus.client_go, 4'b1000);
    checkOutput("round1 idx c3", active_idx, 4'd3);

    frame_tick = 1'b1;
    applyStimulus(1);
    frame_tick = 1'b0;
    checkOutput("tick in run", bus.client_go, 4'b1000);
    bus.client_done[3] = 1'b1;
    applyStimulus(1);
    bus.client_done[3] = 1'b0;
    checkOutput("c3 released", bus.client_go, 4'b0000);
    checkOutput("round_done not yet", round_done, 1'b0);
    applyStimulus(1);
    checkOutput("round1 round_done", round_done, 1'b1);
    applyStimulus(1);
    checkOutput("round_done pulse", round_done, 1'b0);
    checkOutput("err sticky", timeout_err, 1'b1);
    applyStimulus(2);
    checkOutput("tick dropped", bus.client_go, 4'b0000);

    client_mask = 4'b1010; frame_tick = 1'b1;
    applyStimulus(1);
    frame_tick = 1'b0;
    applyStimulus(1);
    checkOutput("mask1010 idx c1", active_idx, 4'd1);
    client_mask = 4'b0000;
    bus.client_done[2] = 1'b1; bus.client_we[2] = 1'b1;
    bus.client_done[1] = 1'b1;
    applyStimulus(1);
    bus.client_done[1] = 1'b0;
    applyStimulus(1);
    checkOutput("mask1010 go c3", bus.client_go, 4'b1000);
    checkOutput("mask1010 idx c3", active_idx, 4'd3);
    checkOutput("skipped we blocked", bus.plot, 1'b0);
    bus.client_done[3] = 1'b1;
    applyStimulus(1);
    bus.client_done[3] = 1'b0;
    applyStimulus(1);
    checkOutput("mask1010 round_done", round_done, 1'b1);
    bus.client_done[2] = 1'b0; bus.client_we[2] = 1'b0;
    applyStimulus(1);

    enable = 1'b0; client_mask = 4'b1110; frame_tick = 1'b1;
    applyStimulus(1);
    frame_tick = 1'b0;
    applyStimulus(1);
    checkOutput("enable low parks", bus.client_go, 4'b0000);

    enable = 1'b1; frame_tick = 1'b1;
    applyStimulus(1);
    frame_tick = 1'b0;
    applyStimulus(1);
    bus.client_done[1] = 1'b1;
    applyStimulus(1);
    bus.client_done[1] = 1'b0;
    applyStimulus(1);
    checkOutput("round3 go c2", bus.client_go, 4'b0100);
    bus.client_we[2] = 1'b1; bus.client_x[23:16] = 8'h7A;
    applyStimulus(1);
    checkOutput("c2 plot", bus.plot, 1'b1);
    checkOutput("c2 x", bus.x_out, 8'h7A);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("midrun reset go", bus.client_go, 4'b0000);
    checkOutput("midrun reset plot", bus.plot, 1'b0);
    checkOutput("midrun reset init_done", init_done, 1'b0);
    checkOutput("midrun reset err", timeout_err, 1'b0);
    reset = 1'b0; bus.client_we[2] = 1'b0;
    applyStimulus(1);
    checkOutput("regrant c0", bus.client_go, 4'b0001);
    checkOutput("regrant idx", active_idx, 4'd0);

    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1);
      if (round_done2) found = 1'b1;
    end
    checkOutput("unpaced first round_done", found, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1);
      checkOutput("unpaced round_done period", round_done2, (k % 3 == 0));
      checkOutput("unpaced go idle", bus2.client_go, 4'b0000);
    end
    checkOutput("unpaced init_done", init_done2, 1'b1);
    checkOutput("no watchdog err", timeout_err2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Parametrised successor to the game-level draw controller: time-multiplexes N drawing clients onto the single VGA adapter pixel-write port.
- Clients include border, ball, paddles and future sprites.
- Runs one init client once after reset, then repeats rounds over the remaining clients with a go/done handshake.
- Adds per-client skip mask, optional frame pacing, watchdog timeout and registered pixel mux.

Parameters:
NUM_CLIENTS, 4, number of drawing clients (2..16); client 0 is the init client
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
C_W, 3, colour width
FRAME_PACE, 1, 1 = each round waits for frame_tick; 0 = rounds run back-to-back
TIMEOUT, 4096, max cycles a client may hold its grant; 0 disables watchdog

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  permit starting new rounds
frame_tick  in  1  one-cycle frame-start pulse
client_mask  in  NUM_CLIENTS  1 = client participates in rounds; bit 0 ignored
client_done  in  NUM_CLIENTS  per-client done; level or pulse
client_we  in  NUM_CLIENTS  per-client pixel write strobe
client_x  in  NUM_CLIENTS*X_W  packed x, client i at [i*X_W +: X_W]
client_y  in  NUM_CLIENTS*Y_W  packed y
client_c  in  NUM_CLIENTS*C_W  packed colour
client_go  out  NUM_CLIENTS  one-hot go to the granted client
plot  out  1  registered write enable to VGA adapter
x_out  out  X_W  registered x
y_out  out  Y_W  registered y
color_out  out  C_W  registered colour
active_idx  out  4  index of the granted client
round_done  out  1  one-cycle pulse at the end of each round
init_done  out  1  sticky; high once client 0 has completed
timeout_err  out  1  sticky; set when any client is aborted by the watchdog

Behaviour:
- Reset (sync, active-high) takes priority over everything.
  - Outputs: client_go=0, plot=0, x_out/y_out/color_out=0, active_idx=0, round_done=0, init_done=0, timeout_err=0.
  - State goes to INIT; watchdog counter cleared.
  - Reset mid-grant drops client_go the next cycle.
- States:
  - INIT: client_go[0]=1, active_idx=0. On client_done[0] (or timeout) -> init_done<=1 -> WAIT.
  - WAIT:
    - FRAME_PACE=1: leave on (enable & frame_tick).
    - FRAME_PACE=0: leave on enable.
    - On leaving: latch mask_r <= client_mask with bit 0 forced 0, idx <= 1 -> SELECT.
  - SELECT (1 cycle, no go asserted):
    - Scan from idx upward for the first set bit of mask_r.
    - Found: active_idx <= it -> RUN.
    - None: round_done pulse -> WAIT.
  - RUN:
    - client_go[active_idx]=1; watchdog counts each cycle.
    - On client_done[active_idx]: go drops the next cycle, idx <= active_idx+1 -> SELECT.
    - Watchdog reaching TIMEOUT-1 without done: same exit, plus timeout_err<=1.
- Go/done handshake:
  - go is held continuously until done is sampled high.
  - done from non-granted clients is ignored.
  - done in the same cycle go first rises is accepted, giving a 1-cycle grant.
  - A client must tolerate go low for at least 1 cycle between grants; SELECT guarantees this.
- Pixel mux:
  - Each cycle: plot <= client_we[sel] & (state is INIT or RUN), where sel is the granted index.
  - x/y/colour register from the same client whenever plot is set; otherwise x/y/colour hold their value.
  - Latency is exactly 1 cycle from client_we to plot.
  - client_we from non-granted clients never reaches plot.
  - A write in the same cycle as done is still forwarded.
- Mask changes during a round have no effect until the next WAIT exit.
- All-zero mask: round_done pulses 2 cycles after the WAIT exit, and no go is asserted.
- frame_tick while not in WAIT is dropped, not queued.
- enable low does not abort a round in progress; the sequencer parks in WAIT.
- With TIMEOUT=0 the watchdog never fires and timeout_err stays 0.

Test Plan:
- Reset then client 0 asserts done after 10 cycles, FRAME_PACE=1, mask=4'b1110, enable=1, tick at cycle 20 -> init_done high at cycle 11; client_go sequence 0001 -> 0010 -> 0100 -> 1000, each with a 1-cycle gap; round_done pulses once after client 3's done.
- Mask=4'b1010 -> only clients 1 and 3 are granted; active_idx sequence 1, 3; client 2 receives no go even when its done/we are driven high.
- Granted client 1 drives we=1, x=8'h25, y=7'h10, c=3'b101 for 1 cycle while client 2 drives we=1 -> plot=1 the following cycle with exactly those values; client 2's data never appears.
- TIMEOUT=16, client 2 never asserts done -> client_go[2] drops after 16 cycles; timeout_err=1 and remains 1; client 3 is granted next.
- FRAME_PACE=0, mask=0 -> round_done pulses every 3 cycles; client_go stays 0.
- Reset asserted mid-RUN of client 2 -> next cycle client_go=0, plot=0, init_done=0; client 0 is re-granted the following cycle.
